// File: rtl/map_sel_hub.sv
// Mapper output selector: a table maps the cartridge mapper number to a slot, and slot
// changes go through a safe-hold window that drives SAFE_OUT before the new slot is committed.
module map_sel_hub #(
    parameter int NSLOT    = 4,
    parameter int OUT_W    = 64,
    parameter int HOLD_CYC = 4,
    parameter int DEF_SLOT = 0,
    parameter logic [OUT_W-1:0] SAFE_OUT = '0,
    parameter int SLOT_W   = (NSLOT > 1) ? $clog2(NSLOT) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             map_idx,
    input  logic [NSLOT*OUT_W-1:0] slot_out,
    input  logic                   tbl_we,
    input  logic [7:0]             tbl_idx,
    input  logic [SLOT_W-1:0]      tbl_slot,
    output logic [OUT_W-1:0]       mao,
    output logic [SLOT_W-1:0]      cur_slot,
    output logic                   switching,
    output logic                   tbl_err
);
    typedef enum logic {RUN, HOLD} state_t;

    localparam logic [SLOT_W-1:0] DEF = SLOT_W'(DEF_SLOT);
    localparam logic [7:0]        CNT_INIT = 8'(HOLD_CYC - 1);

    state_t            state;
    logic [7:0]        cnt;
    logic [SLOT_W-1:0] lat_tgt;
    logic [255:0]      tbl_vld;
    logic [SLOT_W-1:0] tbl_mem [256];
    logic [SLOT_W-1:0] tgt;
    logic              bad;
    logic [OUT_W-1:0]  slot_arr [NSLOT];

    for (genvar s = 0; s < NSLOT; s++) begin : g_unpack
        assign slot_arr[s] = slot_out[s*OUT_W +: OUT_W];
    end

    // Lookup sees the table as it stands this cycle; a same-cycle write lands next cycle.
    assign tgt = tbl_vld[map_idx] ? tbl_mem[map_idx] : DEF;
    assign bad = (32'(tbl_slot) >= NSLOT);

    always_ff @(posedge clk) begin
        if (tbl_we && !bad)
            tbl_mem[tbl_idx] <= tbl_slot;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            cur_slot  <= DEF;
            cnt       <= '0;
            lat_tgt   <= DEF;
            mao       <= SAFE_OUT;
            switching <= 1'b0;
            tbl_err   <= 1'b0;
            tbl_vld   <= '0;
        end else begin
            tbl_err <= tbl_we && bad;
            if (tbl_we && !bad)
                tbl_vld[tbl_idx] <= 1'b1;

            case (state)
                RUN: begin
                    if (tgt == cur_slot) begin
                        mao <= slot_arr[cur_slot];
                    end else begin
                        state     <= HOLD;
                        switching <= 1'b1;
                        lat_tgt   <= tgt;
                        cnt       <= CNT_INIT;
                        mao       <= SAFE_OUT;
                    end
                end
                HOLD: begin
                    mao <= SAFE_OUT;
                    // Any target movement, even back to cur_slot, restarts a full hold.
                    if (tgt != lat_tgt) begin
                        lat_tgt <= tgt;
                        cnt     <= CNT_INIT;
                    end else if (cnt == 8'd0) begin
                        cur_slot  <= lat_tgt;
                        state     <= RUN;
                        switching <= 1'b0;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_map_sel_hub.sv
// Randomized bench for map_sel_hub against an age-counting reference model of the hold rules.
module tb_map_sel_hub;
    localparam int NSLOT = 3;
    localparam int OUT_W = 64;
    localparam int HOLD_CYC = 4;
    localparam int DEF_SLOT = 0;
    localparam int SLOT_W = 2;
    localparam logic [63:0] SAFE = 64'hDEAD_0000_0000_BEEF;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [7:0]             map_idx;
    logic [NSLOT*OUT_W-1:0] slot_out;
    logic                   tbl_we;
    logic [7:0]             tbl_idx;
    logic [SLOT_W-1:0]      tbl_slot;
    logic [OUT_W-1:0]       mao;
    logic [SLOT_W-1:0]      cur_slot;
    logic                   switching;
    logic                   tbl_err;

    map_sel_hub #(.NSLOT(NSLOT), .OUT_W(OUT_W), .HOLD_CYC(HOLD_CYC),
                  .DEF_SLOT(DEF_SLOT), .SAFE_OUT(SAFE)) dut (
        .clk(clk), .rst(rst), .map_idx(map_idx), .slot_out(slot_out),
        .tbl_we(tbl_we), .tbl_idx(tbl_idx), .tbl_slot(tbl_slot),
        .mao(mao), .cur_slot(cur_slot), .switching(switching), .tbl_err(tbl_err));

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Reference: table as arrays; a hold is "pending target + edges since it was last set".
    bit          mv [256];
    int          ms [256];
    int          m_cur;
    bit          m_hold;
    int          m_pend;
    int          m_age;
    logic [63:0] e_mao;
    bit          e_err;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        int tgt;
        tgt = mv[map_idx] ? ms[map_idx] : DEF_SLOT;
        if (rst) begin
            m_hold = 0; m_cur = DEF_SLOT; e_mao = SAFE; e_err = 0;
            foreach (mv[i]) mv[i] = 0;
            return;
        end
        e_err = tbl_we && (int'(tbl_slot) >= NSLOT);
        if (!m_hold) begin
            if (tgt == m_cur) e_mao = slot_out[m_cur*OUT_W +: OUT_W];
            else begin m_hold = 1; m_pend = tgt; m_age = 1; e_mao = SAFE; end
        end else begin
            e_mao = SAFE;
            if (tgt != m_pend) begin m_pend = tgt; m_age = 1; end
            else if (m_age == HOLD_CYC) begin m_cur = m_pend; m_hold = 0; end
            else m_age++;
        end
        if (tbl_we && !e_err) begin mv[tbl_idx] = 1; ms[tbl_idx] = int'(tbl_slot); end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("mao", mao, e_mao);
        chk("cur_slot", 64'(cur_slot), 64'(m_cur));
        chk("switching", 64'(switching), 64'(m_hold));
        chk("tbl_err", 64'(tbl_err), 64'(e_err));
    endtask

    task automatic wr(input int idx, input int s);
        tbl_we = 1; tbl_idx = 8'(idx); tbl_slot = SLOT_W'(s);
        tick();
        tbl_we = 0;
    endtask

    initial begin
        rst = 1; map_idx = 8'd5; tbl_we = 0; tbl_idx = 0; tbl_slot = 0;
        slot_out = {64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111, 64'h0000_0000_0000_00A5};
        tick();
        chk("reset_mao_safe", mao, SAFE);
        rst = 0;
        repeat (3) tick();
        chk("run_slot0", mao, 64'hA5);

        // Table write retargets current map_idx: full hold then slot 2.
        wr(5, 2);
        repeat (6) tick();
        chk("after_switch_slot2", mao, 64'h2222_2222_2222_2222);

        // Mid-hold map_idx change restarts the hold toward slot 1.
        wr(7, 1);
        map_idx = 8'd5;
        wr(5, 0);
        tick();
        map_idx = 8'd7;
        repeat (7) tick();
        chk("restart_commit_slot1", 64'(cur_slot), 64'd1);

        // Rejected write: error pulse, no table change, no switch.
        wr(7, 3);
        repeat (2) tick();
        chk("err_noswitch", 64'(switching), 64'd0);

        // Reset in 2nd hold cycle aborts the switch and clears the table.
        map_idx = 8'd5;
        tick();
        tick();
        rst = 1;
        tick();
        rst = 0;
        repeat (3) tick();
        chk("post_reset_slot0", 64'(cur_slot), 64'd0);

        // Simultaneous write to another index and map_idx change.
        wr(9, 1);
        tbl_we = 1; tbl_idx = 8'd3; tbl_slot = 2'd2; map_idx = 8'd9;
        tick();
        tbl_we = 0;
        repeat (6) tick();

        for (int c = 0; c < 2000; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 5) == 0) map_idx = 8'($urandom_range(0, 7));
            tbl_we = ($urandom_range(0, 4) == 0);
            tbl_idx = 8'($urandom_range(0, 7));
            tbl_slot = SLOT_W'($urandom_range(0, 3));
            for (int w = 0; w < NSLOT*2; w++) slot_out[w*32 +: 32] = $urandom;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
